// File: rtl/rv_instr_encoder.sv
// RV32I instruction encoder: packs I/S/B/U/J fields and expands LI into ADDI or LUI+ADDI.
// Define IMMENC_RANGE_CHK_EN to flag immediates that do not fit their format via out_err.
module rv_instr_encoder #(
  parameter logic [31:0] NOP_WORD = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  in_fmt,
  input  logic [6:0]  in_opcode,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [2:0]  in_funct3,
  input  logic [31:0] in_imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic        out_last,
  output logic        out_err
);

  localparam logic [0:0] StIdle = 1'b0;
  localparam logic [0:0] StLi2  = 1'b1;

  localparam logic [2:0] FmtI  = 3'd0;
  localparam logic [2:0] FmtS  = 3'd1;
  localparam logic [2:0] FmtB  = 3'd2;
  localparam logic [2:0] FmtU  = 3'd3;
  localparam logic [2:0] FmtJ  = 3'd4;
  localparam logic [2:0] FmtLi = 3'd5;

  localparam logic [6:0] OpImm = 7'b0010011;
  localparam logic [6:0] OpLui = 7'b0110111;

  logic [0:0]  state_q, state_d;
  logic        out_valid_q, out_valid_d;
  logic [31:0] out_instr_q, out_instr_d;
  logic        out_last_q, out_last_d;
  logic        out_err_q, out_err_d;
  logic [31:0] addi_q, addi_d;

  logic        accept, out_hs;
  logic [31:0] enc_instr;
  logic        enc_last, enc_err, enc_two;
  logic        fit12;
  logic [19:0] li_hi;
  logic [31:0] li_addi;

  assign in_ready = (state_q == StIdle) & (~out_valid_q | out_ready);
  assign accept   = in_valid & in_ready;
  assign out_hs   = out_valid_q & out_ready;

  // imm[31:11] all equal: value fits a sign-extended 12-bit immediate.
  assign fit12   = (&in_imm[31:11]) | ~(|in_imm[31:11]);
  // ADDI sign-extends its immediate, so LUI pre-compensates with imm[11].
  assign li_hi   = in_imm[31:12] + {19'd0, in_imm[11]};
  assign li_addi = {in_imm[11:0], in_rd, 3'b000, in_rd, OpImm};

`ifdef IMMENC_RANGE_CHK_EN
  logic fit13, fit21;
  assign fit13 = (&in_imm[31:12]) | ~(|in_imm[31:12]);
  assign fit21 = (&in_imm[31:20]) | ~(|in_imm[31:20]);
`endif

  always_comb begin
    enc_instr = NOP_WORD;
    enc_last  = 1'b1;
    enc_err   = 1'b0;
    enc_two   = 1'b0;
    case (in_fmt)
      FmtI: begin
        enc_instr = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
`ifdef IMMENC_RANGE_CHK_EN
        enc_err = ~fit12;
`endif
      end
      FmtS: begin
        enc_instr = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode};
`ifdef IMMENC_RANGE_CHK_EN
        enc_err = ~fit12;
`endif
      end
      FmtB: begin
        enc_instr = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3, in_imm[4:1],
                     in_imm[11], in_opcode};
`ifdef IMMENC_RANGE_CHK_EN
        enc_err = ~fit13 | in_imm[0];
`endif
      end
      FmtU: begin
        enc_instr = {in_imm[31:12], in_rd, in_opcode};
`ifdef IMMENC_RANGE_CHK_EN
        enc_err = |in_imm[11:0];
`endif
      end
      FmtJ: begin
        enc_instr = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, in_opcode};
`ifdef IMMENC_RANGE_CHK_EN
        enc_err = ~fit21 | in_imm[0];
`endif
      end
      FmtLi: begin
        if (fit12) begin
          enc_instr = {in_imm[11:0], 5'd0, 3'b000, in_rd, OpImm};
        end else begin
          enc_instr = {li_hi, in_rd, OpLui};
          enc_last  = 1'b0;
          enc_two   = 1'b1;
        end
      end
      default: enc_err = 1'b1;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    out_instr_d = out_instr_q;
    out_last_d  = out_last_q;
    out_err_d   = out_err_q;
    addi_d      = addi_q;
    if (accept) begin
      out_valid_d = 1'b1;
      out_instr_d = enc_instr;
      out_last_d  = enc_last;
      out_err_d   = enc_err;
      if (enc_two) begin
        state_d = StLi2;
        addi_d  = li_addi;
      end
    end else if (out_hs) begin
      if (state_q == StLi2) begin
        out_instr_d = addi_q;
        out_last_d  = 1'b1;
        out_err_d   = 1'b0;
        state_d     = StIdle;
      end else begin
        out_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      out_valid_q <= 1'b0;
      out_instr_q <= 32'd0;
      out_last_q  <= 1'b0;
      out_err_q   <= 1'b0;
      addi_q      <= 32'd0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      out_instr_q <= out_instr_d;
      out_last_q  <= out_last_d;
      out_err_q   <= out_err_d;
      addi_q      <= addi_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_instr = out_instr_q;
  assign out_last  = out_last_q;
  assign out_err   = out_err_q;

endmodule

// File: doc/rv_instr_encoder.md
Name: rv_instr_encoder

Overview:
- Inverse of the immediate generator: packs opcode, register, funct3 and 32-bit immediate fields into a 32-bit RV32I instruction word. Supported formats are I, S, B, U and J.
- Also expands the LI pseudo-instruction into LUI+ADDI, or into a single ADDI when the value fits in 12 bits.
- Used by the boot-ROM and self-test sequencer to synthesise instructions. Valid/ready on both sides; one registered output stage.

Parameters:
- NOP_WORD, 32'h0000_0013, word emitted for an illegal format.

Ports:
- clk  input  1  clock.
- rst_n  input  1  reset. One clock; reset is asynchronous and active-low.
- in_valid  input  1  request valid.
- in_ready  output  1  encoder can accept a request.
- in_fmt  input  3  0=I, 1=S, 2=B, 3=U, 4=J, 5=LI, 6/7 illegal.
- in_opcode  input  7  opcode field. Ignored for LI.
- in_rd  input  5  rd field.
- in_rs1  input  5  rs1 field.
- in_rs2  input  5  rs2 field.
- in_funct3  input  3  funct3 field. Ignored for U/J/LI.
- in_imm  input  32  immediate, a byte offset for B/J.
- out_valid  output  1  instruction word valid.
- out_ready  input  1  consumer accepts the word.
- out_instr  output  32  encoded instruction.
- out_last  output  1  final beat of this request.
- out_err  output  1  request illegal or out of range.

Behaviour:
- Reset, asynchronous: out_valid=0, out_instr=0, out_last=0, out_err=0, FSM=IDLE. Asserting reset mid-LI drops the pending ADDI beat.
- Handshakes:
  - Input handshake = in_valid & in_ready. Output handshake = out_valid & out_ready.
  - in_ready = (state==IDLE) & (!out_valid | out_ready). This is combinational and gives full throughput of single-beat requests.
  - While out_valid=1 and out_ready=0, out_instr, out_last and out_err hold stable.
- Latency: a request accepted at edge N appears at out_* after edge N. out_valid drops after an output handshake unless a new beat is loaded on the same edge.
- Encoding, fields packed from in_imm:
  - I: {imm[11:0], rs1, funct3, rd, opcode}.
  - S: {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}.
  - B: {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode}.
  - U: {imm[31:12], rd, opcode}.
  - J: {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode}.
  - Round-trip property: for in-range values, decoding out_instr through the immediate generator returns in_imm. For U this requires imm[11:0]=0.
- LI, when imm[31:11] is all equal: one beat, ADDI rd,x0,imm[11:0] (opcode 0010011, funct3 000), out_last=1.
- LI otherwise:
  - Beat 0: LUI rd,hi, where hi = imm[31:12] + imm[11], 20-bit wrap. Opcode 0110111, out_last=0. FSM goes to LI2.
  - Beat 1: loaded on the beat-0 output handshake: ADDI rd,rd,imm[11:0], out_last=1. FSM returns to IDLE.
  - in_ready=0 throughout LI2.
- FSM states:
  - IDLE → LI2 on acceptance of a two-beat LI.
  - LI2 → IDLE on the beat-0 output handshake.
- Illegal fmt (6/7): one beat, out_instr=NOP_WORD, out_err=1, out_last=1.
- All single-beat formats set out_last=1.

Optional Feature:
- Macro IMMENC_RANGE_CHK_EN.
- Defined: out_err=1, with the word still encoded from the truncated fields, when any of these holds:
  - I/S: imm[31:11] not all equal.
  - B: imm[31:12] not all equal, or imm[0]=1.
  - J: imm[31:20] not all equal, or imm[0]=1.
  - U: imm[11:0]≠0.
  - LI never errors.
- Undefined: out_err is set only for an illegal fmt; upper bits are silently truncated.

Test Plan:
- I: fmt=0, opcode=0x13, rd=1, rs1=2, funct3=0, imm=0xFFFFFFFF → one beat 0xFFF10093, out_last=1, out_err=0, one cycle after accept.
- B/J: BEQ rs1=1, rs2=2, imm=8 → 0x00208463. JAL rd=1, imm=0xFFFFFFFC → 0xFFDFF0EF. Feed both through the immediate generator and check the result equals in_imm.
- LI: rd=5, imm=0x12345FFF → 0x123462B7 (out_last=0) then 0xFFF28293 (out_last=1), with in_ready=0 between. LI rd=5, imm=0x7FF → single 0x7FF00293.
- Backpressure: hold out_ready=0 for 5 cycles during LI beat 0 and during back-to-back I requests → out_* stable, in_ready=0, no beat lost or duplicated, order preserved.
- Error: fmt=7 → 0x00000013, out_err=1. With IMMENC_RANGE_CHK_EN: I with imm=0x800 → out_err=1, and B with imm=3 → out_err=1. Without the macro, both give out_err=0.
- Reset: assert rst_n=0 while in LI2 with the beat-0 output stalled → out_valid=0 immediately. After release: in_ready=1, FSM IDLE, and no ADDI beat is emitted.
